// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: drives dec_pc into the decompressor and queues {pc, instr} pairs for the core.
// Define FETCH_LIMIT_EN to stop fetching after LAST_PC and raise fetch_done.
module fetch_prefetch_queue #(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH = 4,
  parameter int PC_STEP = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
`ifdef FETCH_LIMIT_EN
  , parameter logic [ADDR_W-1:0] LAST_PC = 32'h0000_0021
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic [ADDR_W-1:0] dec_pc,
  input  logic [INSTR_W-1:0] dec_instr,
  input  logic redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic out_ready,
`ifdef FETCH_LIMIT_EN
  output logic fetch_done,
`endif
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [2:0] IDLE = 3'd0, RUN = 3'd1, FULL = 3'd2, FLUSH = 3'd3;
`ifdef FETCH_LIMIT_EN
  localparam logic [2:0] DONE = 3'd4;
`endif
  logic [2:0] state, state_n;
  logic [ADDR_W+INSTR_W-1:0] mem [DEPTH];
  logic [PW-1:0] rptr, wptr, rptr_n;
  logic [CW-1:0] count_n, rem;
  logic push, pop, running;
  assign running = (state == RUN) || (state == FULL);
  assign out_valid = count != '0;
  assign pop = out_valid && out_ready && !redirect_valid;
  assign push = running && en && !redirect_valid && (count < CW'(DEPTH) || pop);
  assign count_n = count + CW'(push) - CW'(pop);
  assign rem = count - CW'(pop);
  assign rptr_n = rptr + PW'(pop);
  always_comb begin
    state_n = state;
    if (redirect_valid) state_n = FLUSH;
    else if (state == IDLE || state == FLUSH) state_n = en ? RUN : IDLE;
    else if (running) state_n = !en ? IDLE : (count_n == CW'(DEPTH)) ? FULL : RUN;
`ifdef FETCH_LIMIT_EN
    if (push && dec_pc == LAST_PC) state_n = DONE;
`endif
  end
  always_ff @(posedge clk) if (push) mem[wptr] <= {dec_pc, dec_instr};
  // head is registered so it holds its last value while empty and reads 0 after reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      dec_pc <= RESET_PC;
      rptr <= '0;
      wptr <= '0;
      count <= '0;
      out_pc <= '0;
      out_instr <= '0;
    end else begin
      state <= state_n;
      if (redirect_valid) begin
        dec_pc <= redirect_pc;
        rptr <= '0;
        wptr <= '0;
        count <= '0;
      end else begin
        rptr <= rptr_n;
        wptr <= wptr + PW'(push);
        count <= count_n;
        if (push) dec_pc <= dec_pc + ADDR_W'(PC_STEP);
        if (count_n != '0) {out_pc, out_instr} <= (rem == '0) ? {dec_pc, dec_instr} : mem[rptr_n];
      end
    end
`ifdef FETCH_LIMIT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fetch_done <= 1'b0;
    else if (redirect_valid) fetch_done <= 1'b0;
    else if (push && dec_pc == LAST_PC) fetch_done <= 1'b1;
`endif
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: queue-level reference model plus directed vectors for fetch_prefetch_queue.
module tb_fetch_prefetch_queue;
  logic clk = 0, rst_n = 0, en = 0, redirect_valid = 0, out_ready = 0;
  logic [31:0] dec_pc, dec_instr, redirect_pc = 0, out_instr, out_pc;
  logic out_valid;
  logic [2:0] count;
`ifdef FETCH_LIMIT_EN
  logic fetch_done;
`endif
  int vectors = 0, miscompares = 0;
  fetch_prefetch_queue dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dec_pc(dec_pc), .dec_instr(dec_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready),
`ifdef FETCH_LIMIT_EN
    .fetch_done(fetch_done),
`endif
    .count(count));
  always #5 clk = ~clk;
  assign dec_instr = 32'hA000_0000 | dec_pc;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  // model: a fetch is allowed when en was high last cycle and now, and no redirect last cycle or now
  logic [63:0] mq[$];
  logic [31:0] plog[$];
  logic [31:0] mpc;
  logic pen, pred, mdone, mpop, mpush;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mq.delete();
      mpc = 0; pen = 0; pred = 0; mdone = 0;
    end else begin
      mpop = mq.size() > 0 && out_ready && !redirect_valid;
      mpush = en && pen && !pred && !redirect_valid && !mdone && (mq.size() < 4 || mpop);
      if (redirect_valid) begin
        mq.delete();
        mpc = redirect_pc;
        mdone = 0;
      end else begin
        if (mpop) begin
          plog.push_back(mq[0][63:32]);
          void'(mq.pop_front());
        end
        if (mpush) begin
          mq.push_back({mpc, 32'hA000_0000 | mpc});
`ifdef FETCH_LIMIT_EN
          if (mpc == 32'h21) mdone = 1;
`endif
          mpc = mpc + 1;
        end
      end
      pen = en;
      pred = redirect_valid;
    end
  always @(negedge clk)
    if (rst_n) begin
      chk("count", 64'(count), 64'(mq.size()));
      chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      chk("dec_pc", 64'(dec_pc), 64'(mpc));
`ifdef FETCH_LIMIT_EN
      chk("fetch_done", 64'(fetch_done), 64'(mdone));
`endif
      if (mq.size() > 0) chk("head", {out_pc, out_instr}, mq[0]);
    end
  function automatic logic [31:0] lg(input int i);
    return i < plog.size() ? plog[i] : 32'hDEAD_BEEF;
  endfunction
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input logic e, input logic r);
    rst_n = 0; en = e; out_ready = r; redirect_valid = 0;
    step(2);
    rst_n = 1;
    plog.delete();
  endtask
  initial begin
    #3;
    chk("rst_count", 64'(count), 0);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_pc_instr", {out_pc, out_instr}, 0);
    chk("rst_dec_pc", 64'(dec_pc), 0);
    do_reset(1, 1);
    step(10);
    for (int i = 0; i < 4; i++) chk("free_run_pc", 64'(lg(i)), 64'(i));
    do_reset(1, 0);
    step(8);
    chk("bp_count", 64'(count), 4);
    chk("bp_dec_pc", 64'(dec_pc), 4);
    out_ready = 1;
    plog.delete();
    step(6);
    for (int i = 0; i < 6; i++) chk("drain_pc", 64'(lg(i)), 64'(i));
    chk("full_count", 64'(count), 4);
    en = 0;
    step(1);
    chk("count3", 64'(count), 3);
    en = 1; redirect_valid = 1; redirect_pc = 32'h10;
    step(1);
    redirect_valid = 0;
    chk("redir_count", 64'(count), 0);
    chk("redir_valid", 64'(out_valid), 0);
    plog.delete();
    step(6);
    chk("redir_pc0", 64'(lg(0)), 64'h10);
    chk("redir_pc1", 64'(lg(1)), 64'h11);
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFE;
    step(1);
    redirect_valid = 0;
    plog.delete();
    step(8);
    chk("wrap0", 64'(lg(0)), 64'hFFFF_FFFE);
    chk("wrap1", 64'(lg(1)), 64'hFFFF_FFFF);
    chk("wrap2", 64'(lg(2)), 64'h0);
    chk("wrap3", 64'(lg(3)), 64'h1);
    out_ready = 0; redirect_valid = 1; redirect_pc = 32'h40;
    step(1);
    redirect_valid = 0;
    step(3);
    chk("pre_arst_count", 64'(count), 2);
    chk("pre_arst_head", 64'(out_pc), 64'h40);
    #2 rst_n = 0;
    #1;
    chk("arst_count", 64'(count), 0);
    chk("arst_valid", 64'(out_valid), 0);
    chk("arst_pc_instr", {out_pc, out_instr}, 0);
    chk("arst_dec_pc", 64'(dec_pc), 0);
    do_reset(1, 1);
    step(50);
`ifdef FETCH_LIMIT_EN
    chk("limit_done", 64'(fetch_done), 1);
    chk("limit_delivered", 64'(plog.size()), 34);
    chk("limit_last", 64'(lg(33)), 64'h21);
    chk("limit_dec_pc", 64'(dec_pc), 64'h22);
`else
    chk("unbounded_delivered", 64'(plog.size()), 48);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
